sort4_ctrl: RTL and testbench

SORT4_CTRL -- requirements
Module: sort4_ctrl

---
 rtl/sort4_pkg.sv | 20 ++
 rtl/sort4_cmp4_gate.sv | 29 ++
 rtl/sort4_ctrl.sv | 153 +++++++++++++++
 tb/tb_sort4_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sort4_pkg.sv
// Shared widths, FSM state encoding and helpers for the 4-entry bubble-sort controller.
package sort4_pkg;

    localparam int unsigned DW = 4;
    localparam int unsigned NE = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Index of the last compare in a pass: pass p covers j = 0 .. NE-2-p.
    function automatic logic [IW-1:0] last_j(input logic [IW-1:0] pass);
        return IW'(NE - 2) - pass;
    endfunction

endpackage

// File: rtl/sort4_cmp4_gate.sv
// Gate-level 4-bit unsigned magnitude comparator with one-hot lt/gt/eq outputs.
module cmp4_gate
    import sort4_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          lt_o,
    output logic          gt_o,
    output logic          eq_o
);

    logic [DW-1:0] e;

    assign e = ~(a_i ^ b_i);

    // MSB-first priority: the first differing bit decides the order.
    assign gt_o = (a_i[3] & ~b_i[3])
                | (e[3] & a_i[2] & ~b_i[2])
                | (e[3] & e[2] & a_i[1] & ~b_i[1])
                | (e[3] & e[2] & e[1] & a_i[0] & ~b_i[0]);

    assign lt_o = (~a_i[3] & b_i[3])
                | (e[3] & ~a_i[2] & b_i[2])
                | (e[3] & e[2] & ~a_i[1] & b_i[1])
                | (e[3] & e[2] & e[1] & ~a_i[0] & b_i[0]);

    assign eq_o = &e;

endmodule

// File: rtl/sort4_ctrl.sv
// Load four words, bubble-sort them with one shared comparator, then stream them out ascending.
// Optional swap counter port is enabled by defining SORT4_SWAPCNT_EN.
module sort4_ctrl
    import sort4_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          busy_o
`ifdef SORT4_SWAPCNT_EN
    ,
    output logic [CW-1:0] swap_count_o
`endif
);

    state_e        state_q, state_d;
    logic [DW-1:0] data_q [NE];
    logic [DW-1:0] data_d [NE];
    logic [IW-1:0] ld_idx_q, ld_idx_d;
    logic [IW-1:0] dr_idx_q, dr_idx_d;
    logic [IW-1:0] j_q, j_d;
    logic [IW-1:0] pass_q, pass_d;
    logic          swapped_q, swapped_d;
`ifdef SORT4_SWAPCNT_EN
    logic [CW-1:0] swap_cnt_q, swap_cnt_d;
`endif

    logic [DW-1:0] cmp_a, cmp_b;
    logic          cmp_lt, cmp_gt, cmp_eq;
    logic          swap_c;
    logic [IW-1:0] j_nxt;

    assign j_nxt = j_q + IW'(1);
    assign cmp_a = data_q[j_q];
    assign cmp_b = data_q[j_nxt];

    cmp4_gate u_cmp (
        .a_i  (cmp_a),
        .b_i  (cmp_b),
        .lt_o (cmp_lt),
        .gt_o (cmp_gt),
        .eq_o (cmp_eq)
    );

    // Comparator outputs are one-hot; requiring the other two low keeps equal pairs from swapping.
    assign swap_c = cmp_gt & ~cmp_lt & ~cmp_eq;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        ld_idx_d  = ld_idx_q;
        dr_idx_d  = dr_idx_q;
        j_d       = j_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
`ifdef SORT4_SWAPCNT_EN
        swap_cnt_d = swap_cnt_q;
`endif
        unique case (state_q)
            LOAD: begin
                if (in_valid_i) begin
                    data_d[ld_idx_q] = in_data_i;
                    ld_idx_d         = ld_idx_q + IW'(1);
                    if (ld_idx_q == IW'(NE - 1)) begin
                        state_d   = SORT;
                        ld_idx_d  = '0;
                        pass_d    = '0;
                        j_d       = '0;
                        swapped_d = 1'b0;
`ifdef SORT4_SWAPCNT_EN
                        swap_cnt_d = '0;
`endif
                    end
                end
            end
            SORT: begin
                if (swap_c) begin
                    data_d[j_q]   = cmp_b;
                    data_d[j_nxt] = cmp_a;
`ifdef SORT4_SWAPCNT_EN
                    swap_cnt_d = swap_cnt_q + CW'(1);
`endif
                end
                // End of pass: stop on the final pass or when nothing moved.
                if (j_q == last_j(pass_q)) begin
                    if ((pass_q == IW'(NE - 2)) || !(swapped_q || swap_c)) begin
                        state_d  = DRAIN;
                        dr_idx_d = '0;
                    end else begin
                        pass_d    = pass_q + IW'(1);
                        j_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d       = j_nxt;
                    swapped_d = swapped_q | swap_c;
                end
            end
            DRAIN: begin
                if (out_ready_i) begin
                    dr_idx_d = dr_idx_q + IW'(1);
                    if (dr_idx_q == IW'(NE - 1)) begin
                        state_d  = LOAD;
                        dr_idx_d = '0;
                        ld_idx_d = '0;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            data_q    <= '{default: '0};
            ld_idx_q  <= '0;
            dr_idx_q  <= '0;
            j_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
`ifdef SORT4_SWAPCNT_EN
            swap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            ld_idx_q  <= ld_idx_d;
            dr_idx_q  <= dr_idx_d;
            j_q       <= j_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
`ifdef SORT4_SWAPCNT_EN
            swap_cnt_q <= swap_cnt_d;
`endif
        end
    end

    // Handshake flags decode the state register; reset held low forces them inactive.
    assign in_ready_o  = rst_n && (state_q == LOAD);
    assign out_valid_o = rst_n && (state_q == DRAIN);
    assign busy_o      = rst_n && (state_q == SORT);
    assign out_data_o  = data_q[dr_idx_q];
`ifdef SORT4_SWAPCNT_EN
    assign swap_count_o = swap_cnt_q;
`endif

endmodule

// File: tb/tb_sort4_ctrl.sv
// Scoreboard bench for sort4_ctrl: sorted expectations queued at load, popped at each output handshake.
module tb_sort4_ctrl;
    import sort4_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       busy;
`ifdef SORT4_SWAPCNT_EN
    logic [2:0] swap_count;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic [3:0] exp_q [$];

    sort4_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy)
`ifdef SORT4_SWAPCNT_EN
        ,
        .swap_count_o(swap_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [3:0] w0, input logic [3:0] w1,
                         input logic [3:0] w2, input logic [3:0] w3, input bit push);
        logic [3:0] w [4];
        logic [3:0] s [4];
        logic [3:0] t;
        int n;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        s = w;
        for (int a = 0; a < 3; a++)
            for (int b = a + 1; b < 4; b++)
                if (s[b] < s[a]) begin
                    t = s[a]; s[a] = s[b]; s[b] = t;
                end
        if (push)
            for (int k = 0; k < 4; k++) exp_q.push_back(s[k]);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = w[k];
            n = 0;
            while (!in_ready && n < 20) begin
                tick;
                n++;
            end
            if (n >= 20) check("load_ready_timeout", 32'(in_ready), 32'd1);
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_sort(input string tag, input int exp_cycles, input int exp_swaps);
        int n;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick;
        end
        check({tag, "_sort_cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd1);
`ifdef SORT4_SWAPCNT_EN
        check({tag, "_swap_count"}, 32'(swap_count), 32'(exp_swaps));
`else
        if (exp_swaps < 0) $display("note: negative swap expectation ignored");
`endif
    endtask

    task automatic drain(input string tag, input int stall);
        int n;
        logic [3:0] e;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                tick;
                n++;
            end
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 32'd0, 32'd1);
                e = 4'h0;
            end else begin
                e = exp_q.pop_front();
            end
            if (k == 1 && stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    in_valid = s[0];
                    in_data  = 4'hA;
                    tick;
                    check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                    check({tag, "_stall_data"}, 32'(out_data), 32'(e));
                    check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
                end
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_out_data"}, 32'(out_data), 32'(e));
            tick;
        end
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        tick; tick; tick;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef SORT4_SWAPCNT_EN
        check("rst_swap_count", 32'(swap_count), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        load4(4'h3, 4'h1, 4'h2, 4'h0, 1'b1);
        run_sort("t3120", 6, 5);
        drain("t3120", 0);

        load4(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        run_sort("t1234", 3, 0);
        drain("t1234", 5);

        load4(4'hF, 4'h0, 4'hF, 4'h0, 1'b1);
        run_sort("tF0F0", 6, 3);
        drain("tF0F0", 0);

        load4(4'h9, 4'h9, 4'h9, 4'h9, 1'b1);
        run_sort("t9999", 3, 0);
        in_valid = 1'b1;
        in_data  = 4'h5;
        drain("b2b", 0);
        load4(4'h5, 4'h7, 4'h6, 4'h4, 1'b1);
        run_sort("t5764", 6, 4);
        drain("t5764", 0);

        load4(4'h3, 4'h1, 4'h2, 4'h0, 1'b0);
        tick;
        check("mid_sort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_low_in_ready", 32'(in_ready), 32'd0);
        check("rst_low_busy", 32'(busy), 32'd0);
        tick;
        rst_n = 1'b1;
        #1;
        check("after_rst_in_ready", 32'(in_ready), 32'd1);
        check("after_rst_out_valid", 32'(out_valid), 32'd0);
        check("after_rst_busy", 32'(busy), 32'd0);
`ifdef SORT4_SWAPCNT_EN
        check("after_rst_swap_count", 32'(swap_count), 32'd0);
`endif
        load4(4'h2, 4'h1, 4'h0, 4'h3, 1'b1);
        run_sort("t2103", 6, 3);
        drain("t2103", 0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
